if_stage: RTL and testbench

//  Instruction-fetch stage. Owns the PC, requests words from instruction memory and selects the next PC.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/if_predecode.sv | 29 ++
 rtl/if_stage.sv | 137 +++++++++++++
 tb/tb_if_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: next-PC select, fetch FSM states and the
// MIPS opcode/funct/rt encodings the predecoder needs.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned WADDR  = 30;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_FETCH = 2'b01,
    S_HOLD  = 2'b10
  } if_state_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_BEQL    = 6'b010100;
  localparam logic [5:0] OP_BNEL    = 6'b010101;
  localparam logic [5:0] OP_BLEZL   = 6'b010110;
  localparam logic [5:0] OP_BGTZL   = 6'b010111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZL   = 5'b00010;
  localparam logic [4:0] RT_BGEZL   = 5'b00011;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;
  localparam logic [4:0] RT_BLTZALL = 5'b10010;
  localparam logic [4:0] RT_BGEZALL = 5'b10011;

endpackage

// File: rtl/if_predecode.sv
// Flags instructions whose successor is a delay slot (all branches and jumps).
module if_predecode
  import cpu_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        is_branch_or_jump_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr_i[31:26];
  assign funct         = instr_i[5:0];
  assign unused_fields = ^instr_i[25:6];

  always_comb begin
    is_branch_or_jump_o = 1'b0;
    unique casez (opcode)
      OP_REGIMM:  is_branch_or_jump_o = 1'b1;
      6'b0001??:  is_branch_or_jump_o = 1'b1;
      6'b0101??:  is_branch_or_jump_o = 1'b1;
      6'b00001?:  is_branch_or_jump_o = 1'b1;
      OP_SPECIAL: is_branch_or_jump_o = (funct == FN_JR) || (funct == FN_JALR);
      default:    is_branch_or_jump_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, selects the
// next PC and presents the fetched word straight to the IF/ID register.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMem_Req,
  output logic [29:0] IMem_Addr,
  input  logic        IMem_Ready,
  input  logic [31:0] IMem_RData,
  input  logic        Stall_In,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic        Exception,
  input  logic        Eret,
  input  logic [31:0] EPC,
  output logic [31:0] Instruction,
  output logic [31:0] PCOut,
  output logic [31:0] PCAdd4,
  output logic        IsBDS,
  output logic        IF_Stall,
  output logic        AddrErr
);

  if_state_e   state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q;
  logic        pend_q;
  logic        pend_exc_q;
  logic [31:0] pend_tgt_q;
  logic        isbds_q, isbds_d;

  logic        addr_err;
  logic        fetching;
  logic        holding;
  logic        word_avail;
  logic        redirect;
  logic        kill;
  logic        advance;
  logic        to_hold;
  logic [31:0] instr_raw;
  logic [31:0] pc_plus4;
  logic        departing_bj;

  assign addr_err   = |pc_q[1:0];
  assign fetching   = (state_q == S_FETCH);
  assign holding    = (state_q == S_HOLD);
  assign word_avail = (fetching && (IMem_Ready || addr_err)) || holding;
  assign instr_raw  = holding ? hold_q :
                      (fetching && IMem_Ready && !addr_err) ? IMem_RData : 32'h0;
  assign pc_plus4   = pc_q + 32'd4;

  // Exception/ERET (now or pending) forces an advance even under downstream stall.
  assign redirect = Exception || Eret || pend_q;
  assign kill     = word_avail && redirect;
  assign advance  = word_avail && (redirect || !Stall_In);
  assign to_hold  = fetching && IMem_Ready && !addr_err && Stall_In && !redirect;

  if_predecode u_predecode (
    .instr_i             (instr_raw),
    .is_branch_or_jump_o (departing_bj)
  );

  always_comb begin
    pc_d    = pc_plus4;
    isbds_d = 1'b0;
    if (Exception || (pend_q && pend_exc_q)) begin
      pc_d = EXC_VECTOR;
    end else if (Eret) begin
      pc_d = EPC;
    end else if (pend_q) begin
      pc_d = pend_tgt_q;
    end else begin
      isbds_d = departing_bj;
      unique case (pcsrc_e'(PCSrc))
        PC_BR:   pc_d = BranchTarget;
        PC_JMP:  pc_d = JumpTarget;
        default: pc_d = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      hold_q     <= 32'h0;
      pend_q     <= 1'b0;
      pend_exc_q <= 1'b0;
      pend_tgt_q <= 32'h0;
      isbds_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_BOOT:  state_q <= S_FETCH;
        S_FETCH: if (to_hold) state_q <= S_HOLD;
        S_HOLD:  if (advance) state_q <= S_FETCH;
        default: state_q <= S_BOOT;
      endcase

      if (to_hold) hold_q <= IMem_RData;

      if (advance) begin
        pc_q       <= pc_d;
        isbds_q    <= isbds_d;
        pend_q     <= 1'b0;
        pend_exc_q <= 1'b0;
      end else if (Exception) begin
        pend_q     <= 1'b1;
        pend_exc_q <= 1'b1;
        pend_tgt_q <= EXC_VECTOR;
        isbds_q    <= 1'b0;
      end else if (Eret) begin
        // A pending exception is never displaced by a later ERET.
        if (!(pend_q && pend_exc_q)) begin
          pend_q     <= 1'b1;
          pend_tgt_q <= EPC;
        end
        isbds_q <= 1'b0;
      end
    end
  end

  assign IMem_Req    = fetching && !addr_err;
  assign IMem_Addr   = pc_q[31:2];
  assign Instruction = kill ? 32'h0 : instr_raw;
  assign PCOut       = pc_q;
  assign PCAdd4      = pc_plus4;
  assign IsBDS       = isbds_q && !kill;
  assign IF_Stall    = !word_avail;
  assign AddrErr     = addr_err;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, wait states, delay slot,
// downstream hold, exception/ERET redirects, address error, wrap and reset.
module tb_if_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IMem_Req;
  logic [29:0] IMem_Addr;
  logic        IMem_Ready;
  logic [31:0] IMem_RData;
  logic        Stall_In;
  logic [1:0]  PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] JumpTarget;
  logic        Exception;
  logic        Eret;
  logic [31:0] EPC;
  logic [31:0] Instruction;
  logic [31:0] PCOut;
  logic [31:0] PCAdd4;
  logic        IsBDS;
  logic        IF_Stall;
  logic        AddrErr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  // Memory: BEQ at byte 0x100, otherwise {2'b10, word address} (never a branch).
  assign IMem_RData = (IMem_Addr == 30'h40) ? 32'h1000_0003 : {2'b10, IMem_Addr};

  if_stage dut (
    .CLK          (CLK),
    .RST          (RST),
    .IMem_Req     (IMem_Req),
    .IMem_Addr    (IMem_Addr),
    .IMem_Ready   (IMem_Ready),
    .IMem_RData   (IMem_RData),
    .Stall_In     (Stall_In),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .JumpTarget   (JumpTarget),
    .Exception    (Exception),
    .Eret         (Eret),
    .EPC          (EPC),
    .Instruction  (Instruction),
    .PCOut        (PCOut),
    .PCAdd4       (PCAdd4),
    .IsBDS        (IsBDS),
    .IF_Stall     (IF_Stall),
    .AddrErr      (AddrErr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; IMem_Ready = 1'b1; Stall_In = 1'b0; PCSrc = 2'b00;
    BranchTarget = 32'h0; JumpTarget = 32'h0; Exception = 1'b0; Eret = 1'b0; EPC = 32'h0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req",   32'(IMem_Req), 32'h0);
    check("rst_stall", 32'(IF_Stall), 32'h1);
    check("rst_pc",    PCOut,         32'hBFC0_0000);
    check("rst_pc4",   PCAdd4,        32'hBFC0_0004);
    check("rst_instr", Instruction,   32'h0);
    check("rst_bds",   32'(IsBDS),    32'h0);
    check("rst_aerr",  32'(AddrErr),  32'h0);
    RST = 1'b0;

    // 1: zero-wait sequential fetch
    tick();
    check("s1_addr0",  32'(IMem_Addr), 32'h2FF0_0000);
    check("s1_req0",   32'(IMem_Req),  32'h1);
    check("s1_pc0",    PCOut,          32'hBFC0_0000);
    check("s1_instr0", Instruction,    32'hAFF0_0000);
    check("s1_stall0", 32'(IF_Stall),  32'h0);
    tick();
    check("s1_addr1",  32'(IMem_Addr), 32'h2FF0_0001);
    check("s1_pc1",    PCOut,          32'hBFC0_0004);
    check("s1_pc4_1",  PCAdd4,         32'hBFC0_0008);
    check("s1_instr1", Instruction,    32'hAFF0_0001);

    // 2: three wait states, then exactly one advance
    IMem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s2_wait_stall", 32'(IF_Stall),  32'h1);
      check("s2_wait_addr",  32'(IMem_Addr), 32'h2FF0_0001);
      tick();
    end
    IMem_Ready = 1'b1;
    #1;
    check("s2_rdy_stall", 32'(IF_Stall), 32'h0);
    check("s2_rdy_instr", Instruction,   32'hAFF0_0001);
    tick();
    check("s2_pc_once",   PCOut,         32'hBFC0_0008);

    // 3: ERET to 0x100 (kills current word), BEQ then delay slot then target
    Eret = 1'b1; EPC = 32'h0000_0100;
    #1;
    check("s3_eret_kill", Instruction, 32'h0);
    tick();
    Eret = 1'b0;
    #1;
    check("s3_pc_beq",    PCOut,       32'h0000_0100);
    check("s3_instr_beq", Instruction, 32'h1000_0003);
    check("s3_bds_beq",   32'(IsBDS),  32'h0);
    tick();
    PCSrc = 2'b01; BranchTarget = 32'h0000_0200;
    #1;
    check("s3_pc_slot",    PCOut,       32'h0000_0104);
    check("s3_bds_slot",   32'(IsBDS),  32'h1);
    check("s3_instr_slot", Instruction, 32'h8000_0041);
    tick();
    PCSrc = 2'b00;
    #1;
    check("s3_pc_tgt",  PCOut,       32'h0000_0200);
    check("s3_bds_tgt", 32'(IsBDS),  32'h0);
    check("s3_instr_tgt", Instruction, 32'h8000_0080);

    // 4: downstream stall as the word returns -> hold buffer
    Stall_In = 1'b1;
    tick();
    IMem_Ready = 1'b0;
    #1;
    check("s4_hold_req",   32'(IMem_Req), 32'h0);
    check("s4_hold_instr", Instruction,   32'h8000_0080);
    check("s4_hold_pc",    PCOut,         32'h0000_0200);
    check("s4_hold_stall", 32'(IF_Stall), 32'h0);
    tick();
    Stall_In = 1'b0;
    #1;
    check("s4_hold2_instr", Instruction, 32'h8000_0080);
    IMem_Ready = 1'b1;
    tick();
    check("s4_resume_pc",    PCOut,         32'h0000_0204);
    check("s4_resume_req",   32'(IMem_Req), 32'h1);
    check("s4_resume_instr", Instruction,   32'h8000_0081);

    // 5: exception mid-wait, later ERET must not displace it
    IMem_Ready = 1'b0; Exception = 1'b1;
    #1;
    check("s5_exc_stall", 32'(IF_Stall), 32'h1);
    tick();
    Exception = 1'b0; Eret = 1'b1; EPC = 32'h0000_0300;
    #1;
    check("s5_addr_stable", 32'(IMem_Addr), 32'h0000_0081);
    tick();
    Eret = 1'b0; IMem_Ready = 1'b1;
    #1;
    check("s5_killed",  Instruction,  32'h0);
    check("s5_bds",     32'(IsBDS),   32'h0);
    check("s5_stall",   32'(IF_Stall), 32'h0);
    tick();
    check("s5_exc_addr", 32'(IMem_Addr), 32'h2000_0060);
    check("s5_exc_pc",   PCOut,          32'h8000_0180);

    // 6: ERET to misaligned PC, then wrap at top of address space
    Eret = 1'b1; EPC = 32'h0000_0403;
    #1;
    check("s6_eret_kill", Instruction, 32'h0);
    tick();
    Eret = 1'b0;
    #1;
    check("s6_aerr",       32'(AddrErr),  32'h1);
    check("s6_aerr_req",   32'(IMem_Req), 32'h0);
    check("s6_aerr_instr", Instruction,   32'h0);
    check("s6_aerr_stall", 32'(IF_Stall), 32'h0);
    Eret = 1'b1; EPC = 32'hFFFF_FFFC;
    tick();
    Eret = 1'b0;
    #1;
    check("s6_top_pc",    PCOut,        32'hFFFF_FFFC);
    check("s6_top_pc4",   PCAdd4,       32'h0000_0000);
    check("s6_top_aerr",  32'(AddrErr), 32'h0);
    check("s6_top_instr", Instruction,  32'hBFFF_FFFF);
    tick();
    check("s6_wrap_pc",    PCOut,       32'h0000_0000);
    check("s6_wrap_instr", Instruction, 32'h8000_0000);

    // Async reset mid-fetch drops the request without a clock edge
    IMem_Ready = 1'b0;
    tick();
    check("s6_pre_rst_req", 32'(IMem_Req), 32'h1);
    #2;
    RST = 1'b1;
    #1;
    check("s6_arst_req",   32'(IMem_Req), 32'h0);
    check("s6_arst_pc",    PCOut,         32'hBFC0_0000);
    check("s6_arst_stall", 32'(IF_Stall), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
